// File: rtl/spi_master_ctrl_if.sv
// Request/response bundle between the AHB-Lite bridge and spi_master_ctrl.
// The bridge uses the master modport; the SPI controller uses the slave modport.
interface spi_master_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        txn_done;
  logic        busy;

  modport master (
    output req_valid,
    output req_write,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  rd_data,
    input  rd_valid,
    input  txn_done,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output rd_data,
    output rd_valid,
    output txn_done,
    output busy
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master: serialises {wr, addr, wdata} MSB first and, for reads, clocks in 32 bits.
// Optional feature macro SPI_LOOPBACK_EN: sample mosi instead of miso and replay wdata in RDATA.
module spi_master_ctrl #(
  parameter int CLK_DIV      = 4,
  parameter int CS_SETUP_CYC = 2,
  parameter int TURN_CYC     = 4,
  parameter int CS_HOLD_CYC  = 2
) (
  input  logic             SCLK,
  input  logic             SRESETn,
  spi_master_ctrl_if.slave bus,
  output logic             spi_clk,
  output logic             cs,
  output logic             mosi,
  input  logic             miso
);

  localparam int MAX_AB  = (CLK_DIV > TURN_CYC) ? CLK_DIV : TURN_CYC;
  localparam int MAX_CS  = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
  localparam int MAX_CNT = (MAX_AB > MAX_CS) ? MAX_AB : MAX_CS;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_CMD      = 3'd2,
    ST_TURN     = 3'd3,
    ST_RDATA    = 3'd4,
    ST_CS_HOLD  = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  cyc_r;
  logic [5:0]        bit_r;
  logic [40:0]       shreg_r;
  logic [31:0]       rx_r;
  logic              is_read_r;
  logic              sample_s;

`ifdef SPI_LOOPBACK_EN
  logic [31:0]       lb_r;
  assign sample_s = mosi;
`else
  assign sample_s = miso;
`endif

  // Transaction sequencer; all pin and handshake outputs are registered here.
  always_ff @(posedge SCLK or negedge SRESETn) begin
    if (!SRESETn) begin
      state_r       <= ST_IDLE;
      cs            <= 1'b1;
      spi_clk       <= 1'b0;
      mosi          <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.busy      <= 1'b0;
      bus.txn_done  <= 1'b0;
      bus.rd_valid  <= 1'b0;
      bus.rd_data   <= 32'h0000_0000;
      cyc_r         <= CNT_ZERO;
      bit_r         <= 6'd0;
      shreg_r       <= 41'h0;
      rx_r          <= 32'h0000_0000;
      is_read_r     <= 1'b0;
`ifdef SPI_LOOPBACK_EN
      lb_r          <= 32'h0000_0000;
`endif
    end else begin
      bus.txn_done <= 1'b0;
      bus.rd_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            state_r       <= ST_CS_SETUP;
            cs            <= 1'b0;
            bus.busy      <= 1'b1;
            bus.req_ready <= 1'b0;
            cyc_r         <= CNT_ZERO;
            shreg_r       <= {bus.req_write, bus.req_addr, bus.req_wdata};
            is_read_r     <= ~bus.req_write;
`ifdef SPI_LOOPBACK_EN
            lb_r          <= bus.req_wdata;
`endif
          end
        end

        ST_CS_SETUP: begin
          if (cyc_r == SETUP_LAST) begin
            state_r <= ST_CMD;
            cyc_r   <= CNT_ZERO;
            bit_r   <= 6'd41;
            mosi    <= shreg_r[40];
            shreg_r <= {shreg_r[39:0], 1'b0};
          end else begin
            cyc_r <= cyc_r + CNT_ONE;
          end
        end

        // Each bit period: mosi set on cycle 0, spi_clk high for the second half.
        ST_CMD: begin
          if (cyc_r == DIV_LAST) begin
            cyc_r   <= CNT_ZERO;
            spi_clk <= 1'b0;
            if (bit_r == 6'd1) begin
              bit_r   <= 6'd0;
              mosi    <= 1'b0;
              state_r <= is_read_r ? ST_TURN : ST_CS_HOLD;
            end else begin
              bit_r   <= bit_r - 6'd1;
              mosi    <= shreg_r[40];
              shreg_r <= {shreg_r[39:0], 1'b0};
            end
          end else begin
            cyc_r <= cyc_r + CNT_ONE;
            if (cyc_r == HALF_LAST) begin
              spi_clk <= 1'b1;
            end
          end
        end

        ST_TURN: begin
          if (cyc_r == TURN_LAST) begin
            state_r <= ST_RDATA;
            cyc_r   <= CNT_ZERO;
            bit_r   <= 6'd32;
`ifdef SPI_LOOPBACK_EN
            mosi    <= lb_r[31];
            lb_r    <= {lb_r[30:0], 1'b0};
`else
            mosi    <= 1'b0;
`endif
          end else begin
            cyc_r <= cyc_r + CNT_ONE;
          end
        end

        // miso is captured on the same edge that raises spi_clk.
        ST_RDATA: begin
          if (cyc_r == DIV_LAST) begin
            cyc_r   <= CNT_ZERO;
            spi_clk <= 1'b0;
            if (bit_r == 6'd1) begin
              bit_r   <= 6'd0;
              mosi    <= 1'b0;
              state_r <= ST_CS_HOLD;
            end else begin
              bit_r <= bit_r - 6'd1;
`ifdef SPI_LOOPBACK_EN
              mosi  <= lb_r[31];
              lb_r  <= {lb_r[30:0], 1'b0};
`else
              mosi  <= 1'b0;
`endif
            end
          end else begin
            cyc_r <= cyc_r + CNT_ONE;
            if (cyc_r == HALF_LAST) begin
              spi_clk <= 1'b1;
              rx_r    <= {rx_r[30:0], sample_s};
            end
          end
        end

        ST_CS_HOLD: begin
          if (cyc_r == HOLD_LAST) begin
            state_r      <= ST_DONE;
            cyc_r        <= CNT_ZERO;
            cs           <= 1'b1;
            bus.txn_done <= 1'b1;
            if (is_read_r) begin
              bus.rd_data  <= rx_r;
              bus.rd_valid <= 1'b1;
            end
          end else begin
            cyc_r <= cyc_r + CNT_ONE;
          end
        end

        ST_DONE: begin
          state_r       <= ST_IDLE;
          cs            <= 1'b1;
          bus.busy      <= 1'b0;
          bus.req_ready <= 1'b1;
        end

        default: begin
          state_r       <= ST_IDLE;
          cs            <= 1'b1;
          spi_clk       <= 1'b0;
          mosi          <= 1'b0;
          bus.busy      <= 1'b0;
          bus.req_ready <= 1'b1;
          cyc_r         <= CNT_ZERO;
          bit_r         <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: driver pushes model predictions at accept,
// a monitor pops and compares on every txn_done; a small slave model drives miso.
module tb_spi_master_ctrl;
  localparam int CLK_DIV      = 4;
  localparam int CS_SETUP_CYC = 2;
  localparam int TURN_CYC     = 4;
  localparam int CS_HOLD_CYC  = 2;

  logic SCLK    = 1'b0;
  logic SRESETn = 1'b0;
  logic miso    = 1'b0;
  logic spi_clk;
  logic cs;
  logic mosi;

  spi_master_ctrl_if bus();

  spi_master_ctrl #(
    .CLK_DIV      (CLK_DIV),
    .CS_SETUP_CYC (CS_SETUP_CYC),
    .TURN_CYC     (TURN_CYC),
    .CS_HOLD_CYC  (CS_HOLD_CYC)
  ) dut (
    .SCLK    (SCLK),
    .SRESETn (SRESETn),
    .bus     (bus),
    .spi_clk (spi_clk),
    .cs      (cs),
    .mosi    (mosi),
    .miso    (miso)
  );

  always #5 SCLK = ~SCLK;

  typedef struct {
    bit          is_read;
    logic [31:0] exp_rd;
    int          exp_done;
    logic [72:0] exp_bits;
    int          exp_rises;
    int          exp_gap;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks        = 0;
  int          errors        = 0;
  int          cyc_cnt       = 0;
  int          rise_cnt      = 0;
  int          hi_run        = 0;
  int          last_done_cyc = -100;
  logic [31:0] last_rd       = 32'h0;
  logic [31:0] cur_slave     = 32'h0;
  bit          mosi_bits[$];
  logic [72:0] got_bits;

  always @(posedge SCLK) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: packet, latency and read result straight from the protocol rules.
  function automatic exp_t model(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] slave, input int acc_cyc, input int gap);
    exp_t        e;
    logic [40:0] pkt;
    logic [31:0] rd_mosi;
    logic [31:0] rd_src;
    pkt = {wr, addr, wdata};
`ifdef SPI_LOOPBACK_EN
    rd_mosi = wdata;
    rd_src  = wdata;
`else
    rd_mosi = 32'h0;
    rd_src  = slave;
`endif
    e.is_read   = !wr;
    e.exp_rd    = rd_src;
    e.exp_rises = wr ? 41 : 73;
    e.exp_done  = acc_cyc + 1 + CS_SETUP_CYC + 41 * CLK_DIV + CS_HOLD_CYC
                  + (wr ? 0 : TURN_CYC + 32 * CLK_DIV);
    e.exp_bits  = wr ? {pkt, 32'h0} : {pkt, rd_mosi};
    e.exp_gap   = gap;
    return e;
  endfunction

  // Bit collector: every spi_clk rise records mosi; a cs fall starts a new frame.
  always @(posedge spi_clk or negedge cs) begin
    if (spi_clk) begin
      rise_cnt++;
      mosi_bits.push_back(mosi);
    end else begin
      rise_cnt = 0;
      mosi_bits.delete();
    end
  end

  // Slave model: after the 41 command bits, present data MSB first on each spi_clk fall.
  always @(negedge spi_clk) begin
    if (rise_cnt >= 41 && rise_cnt < 73) miso = cur_slave[31 - (rise_cnt - 41)];
    else miso = 1'b0;
  end

  // Monitor / scoreboard.
  always @(negedge SCLK) begin
    if (SRESETn) begin
      if (cs) begin
        hi_run++;
      end else begin
        if (hi_run > 0 && sb_q.size() > 0 && sb_q[0].exp_gap >= 0)
          chk("cs_high_gap", 64'(hi_run), 64'(sb_q[0].exp_gap));
        hi_run = 0;
      end
      chk("ready_vs_busy", 64'(bus.req_ready), 64'(!bus.busy));
      if (bus.rd_valid && !bus.txn_done) begin
        checks++;
        errors++;
        $display("FAIL rd_valid_without_done: got rd_valid=1, expected 0");
      end
      if (bus.txn_done) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_txn_done: got txn_done=1, expected no transaction");
        end else begin
          mon_e = sb_q.pop_front();
          got_bits = '0;
          for (int i = 0; i < mosi_bits.size() && i < 73; i++) got_bits[72 - i] = mosi_bits[i];
          chk("done_cycle", 64'(cyc_cnt), 64'(mon_e.exp_done));
          chk("spi_clk_rises", 64'(rise_cnt), 64'(mon_e.exp_rises));
          checks++;
          if (got_bits !== mon_e.exp_bits) begin
            errors++;
            $display("FAIL mosi_bits: got 0x%0h, expected 0x%0h", got_bits, mon_e.exp_bits);
          end
          chk("rd_valid", 64'(bus.rd_valid), 64'(mon_e.is_read));
          chk("cs_high_at_done", 64'(cs), 64'(1'b1));
          if (mon_e.is_read) begin
            chk("rd_data", 64'(bus.rd_data), 64'(mon_e.exp_rd));
            last_rd = mon_e.exp_rd;
          end else begin
            chk("rd_data_hold", 64'(bus.rd_data), 64'(last_rd));
          end
          last_done_cyc = cyc_cnt;
        end
      end
    end
  end

  // Issue one request; caller is at a negedge. Prediction is pushed at accept.
  task automatic do_txn(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                        input logic [31:0] slave, input int gap, input bit hold, input bit chk_b2b);
    bit acc;
    acc           = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    for (int t = 0; t < 3000; t++) begin
      if (bus.req_ready) begin
        acc = 1'b1;
        break;
      end
      @(negedge SCLK);
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept, expected accept within 3000 cycles");
      bus.req_valid = 1'b0;
    end else begin
      if (chk_b2b) chk("b2b_accept_cycle", 64'(cyc_cnt), 64'(last_done_cyc + 1));
      cur_slave = slave;
      sb_q.push_back(model(wr, addr, wdata, slave, cyc_cnt, gap));
      @(negedge SCLK);
      if (!hold) bus.req_valid = 1'b0;
      bus.req_write = 1'($urandom_range(0, 1));
      bus.req_addr  = 8'($urandom);
      bus.req_wdata = $urandom;
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      if (sb_q.size() == 0 && !bus.busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge SCLK);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cs"}, 64'(cs), 64'(1'b1));
    chk({tag, "_spi_clk"}, 64'(spi_clk), 64'(1'b0));
    chk({tag, "_mosi"}, 64'(mosi), 64'(1'b0));
    chk({tag, "_busy"}, 64'(bus.busy), 64'(1'b0));
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'(1'b1));
    chk({tag, "_rd_data"}, 64'(bus.rd_data), 64'(32'h0));
    chk({tag, "_txn_done"}, 64'(bus.txn_done), 64'(1'b0));
  endtask

  initial begin
    bit reached;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 32'h0;

    repeat (3) @(negedge SCLK);
    chk_reset_outputs("reset");
    SRESETn = 1'b1;
    @(negedge SCLK);

    do_txn(1'b1, 8'h3C, 32'hDEADBEEF, 32'h0, -1, 1'b0, 1'b0);
    drain();
    do_txn(1'b0, 8'h05, 32'h0000_0000, 32'hA5A5_0F0F, -1, 1'b0, 1'b0);
    drain();
    do_txn(1'b0, 8'h11, 32'h1234_5678, 32'h0, -1, 1'b0, 1'b0);
    drain();

    repeat (3) @(negedge SCLK);
    do_txn(1'b1, 8'h21, 32'h0102_0304, 32'h0, -1, 1'b1, 1'b0);
    do_txn(1'b1, 8'h22, 32'hF0E1_D2C3, 32'h0, 2, 1'b0, 1'b1);
    drain();

    for (int i = 0; i < 12; i++) begin
      do_txn(1'($urandom_range(0, 1)), 8'($urandom), $urandom, $urandom, -1, 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge SCLK);
    end
    drain();

    do_txn(1'b1, 8'h7E, 32'hCAFE_F00D, 32'h0, -1, 1'b0, 1'b0);
    reached = 1'b0;
    for (int t = 0; t < 500; t++) begin
      if (rise_cnt >= 20) begin
        reached = 1'b1;
        break;
      end
      @(negedge SCLK);
    end
    chk("reached_bit20", 64'(reached), 64'(1'b1));
    SRESETn = 1'b0;
    #1;
    chk_reset_outputs("midcmd_reset");
    sb_q.delete();
    last_rd = 32'h0;
    @(negedge SCLK);
    SRESETn = 1'b1;
    @(negedge SCLK);

    do_txn(1'b1, 8'h3C, 32'h0BAD_C0DE, 32'h0, -1, 1'b0, 1'b0);
    drain();
    do_txn(1'b0, 8'h44, 32'h5555_AAAA, 32'h3C3C_C3C3, -1, 1'b0, 1'b0);
    drain();

    repeat (4) @(negedge SCLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
